// File: rtl/memory_stage.sv
// memory_stage: memory-access pipeline stage between the execute register
// and the memory/writeback register.
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   dataE                  registered execute bundle (address/ALU result, store data, control)
//   dataM                  memory bundle for the memory/writeback register
//   stallM                 high while a dbus transaction is outstanding; holds upstream
//   dreq_valid/addr/size/strobe/data   dbus request
//   dresp_addr_ok          address accepted (not used for sequencing)
//   dresp_data_ok          transaction complete
//   dresp_data             read data, full 8-byte lane
//
// state | meaning
// IDLE  | no transaction; dataM follows dataE, request issued straight from dataE
// WAIT  | request outstanding, held from the request register
// DONE  | response captured; dataM shows the load result for one cycle

package memory_pkg;
  localparam int XLEN = 64;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic [1:0] msize;
    logic       mem_unsigned;
    logic       regwrite;
    logic       nop_signal;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result_alu;
    logic [XLEN-1:0] wd;
    logic [4:0]      wa;
    ctl_t            ctl;
  } execute_data_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] result;
    logic [4:0]      wa;
    ctl_t            ctl;
    logic            misalign;
    logic            valid;
  } memory_data_t;
endpackage

module memory_stage
  import memory_pkg::*;
#(
  parameter int XLEN     = memory_pkg::XLEN,
  parameter int STROBE_W = XLEN / 8
) (
  input  logic                clk,
  input  logic                reset,
  input  execute_data_t       dataE,
  output memory_data_t        dataM,
  output logic                stallM,
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [STROBE_W-1:0] dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic [1:0]          size;
    logic                uns;
    logic [STROBE_W-1:0] strobe;
    logic [XLEN-1:0]     data;
  } req_t;

  state_t          state, state_next;
  req_t            req_d, req_q, req_out;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] rdata_ext;
  logic [STROBE_W-1:0] size_mask;
  logic            mem_op;
  logic            misaligned;
  logic            sgn;

  // Completion is defined only by data_ok; address acceptance is ignored.
  logic unused_addr_ok;
  assign unused_addr_ok = dresp_addr_ok;

  // Request as it would be issued from the current execute bundle.
  always_comb begin
    mem_op = !dataE.ctl.nop_signal && (dataE.ctl.memread || dataE.ctl.memwrite);

    misaligned = 1'b0;
    size_mask  = '1;
    case (dataE.ctl.msize)
      2'd0: size_mask = STROBE_W'(8'h01);
      2'd1: begin
        size_mask  = STROBE_W'(8'h03);
        misaligned = dataE.result_alu[0];
      end
      2'd2: begin
        size_mask  = STROBE_W'(8'h0F);
        misaligned = dataE.result_alu[1:0] != 2'b00;
      end
      default: begin
        size_mask  = '1;
        misaligned = dataE.result_alu[2:0] != 3'b000;
      end
    endcase

    req_d.addr   = dataE.result_alu;
    req_d.size   = dataE.ctl.msize;
    req_d.uns    = dataE.ctl.mem_unsigned;
    req_d.strobe = dataE.ctl.memwrite ? (size_mask << dataE.result_alu[2:0]) : '0;
    req_d.data   = dataE.wd << {dataE.result_alu[2:0], 3'b000};
  end

  // Load extraction always works on the registered request, which is what
  // the bus is answering.
  always_comb begin
    shifted = dresp_data >> {req_q.addr[2:0], 3'b000};
    sgn     = !req_q.uns;
    case (req_q.size)
      2'd0:    rdata_ext = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
      2'd1:    rdata_ext = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
      2'd2:    rdata_ext = {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]};
      default: rdata_ext = dresp_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req_q    <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == WAIT)
        req_q <= req_d;
      if (state == WAIT && dresp_data_ok)
        result_q <= rdata_ext;
    end
  end

  always_comb begin
    state_next     = state;
    stallM         = 1'b0;
    dreq_valid     = 1'b0;
    dataM.pc       = dataE.pc;
    dataM.result   = dataE.result_alu;
    dataM.wa       = dataE.wa;
    dataM.ctl      = dataE.ctl;
    dataM.misalign = 1'b0;
    dataM.valid    = !dataE.ctl.nop_signal;

    case (state)
      IDLE: begin
        if (mem_op && misaligned) begin
          dataM.misalign     = 1'b1;
          dataM.ctl.regwrite = 1'b0;
          dataM.ctl.memwrite = 1'b0;
        end else if (mem_op) begin
          dreq_valid  = 1'b1;
          stallM      = 1'b1;
          dataM.valid = 1'b0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        dreq_valid  = 1'b1;
        stallM      = 1'b1;
        dataM.valid = 1'b0;
        if (dresp_data_ok)
          state_next = DONE;
      end
      DONE: begin
        dataM.result = result_q;
        dataM.valid  = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_out     = (state == IDLE) ? req_d : req_q;
  assign dreq_addr   = req_out.addr;
  assign dreq_size   = {1'b0, req_out.size};
  assign dreq_strobe = req_out.strobe;
  assign dreq_data   = req_out.data;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: a vector table for single-cycle and
// complete bus transactions, plus hand-written reset/late-response sequences.
module tb_memory_stage;
  import memory_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  memory_data_t  dataM;
  logic          stallM, dreq_valid;
  logic [63:0]   dreq_addr, dreq_data, dresp_data;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic          dresp_addr_ok, dresp_data_ok;

  int errors = 0;
  int checks = 0;

  memory_stage dut (
    .clk(clk), .reset(reset), .dataE(dataE), .dataM(dataM), .stallM(stallM),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [63:0] wd;
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns, nop, rw;
    int          lat;
    logic [63:0] rdata;
    logic        exp_req;
    logic [7:0]  exp_strobe;
    logic [63:0] exp_data;
    logic [63:0] exp_result;
    logic        exp_mis, exp_valid, exp_rw, exp_mw;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, logic [63:0] addr, logic [63:0] wd,
                              logic rd, logic wr, logic [1:0] sz, logic uns, logic nop,
                              logic rw, int lat, logic [63:0] rdata, logic exp_req,
                              logic [7:0] exp_strobe, logic [63:0] exp_data,
                              logic [63:0] exp_result, logic exp_mis, logic exp_valid,
                              logic exp_rw, logic exp_mw);
    vec_t v;
    v.name = name; v.addr = addr; v.wd = wd; v.rd = rd; v.wr = wr; v.sz = sz;
    v.uns = uns; v.nop = nop; v.rw = rw; v.lat = lat; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_strobe = exp_strobe; v.exp_data = exp_data;
    v.exp_result = exp_result; v.exp_mis = exp_mis; v.exp_valid = exp_valid;
    v.exp_rw = exp_rw; v.exp_mw = exp_mw;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_bubble();
    dataE = '0;
    dataE.ctl.nop_signal = 1'b1;
  endtask

  task automatic drive(vec_t v);
    dataE.pc               = ~v.addr;
    dataE.result_alu       = v.addr;
    dataE.wd               = v.wd;
    dataE.wa               = 5'd7;
    dataE.ctl.memread      = v.rd;
    dataE.ctl.memwrite     = v.wr;
    dataE.ctl.msize        = v.sz;
    dataE.ctl.mem_unsigned = v.uns;
    dataE.ctl.regwrite     = v.rw;
    dataE.ctl.nop_signal   = v.nop;
  endtask

  task automatic run_vec(vec_t v);
    int stalls;
    @(posedge clk); #1;
    drive(v);
    dresp_data_ok = 1'b0;
    dresp_data    = 64'hA5A5_A5A5_A5A5_A5A5;
    @(negedge clk);
    chk({v.name, " dreq_valid"}, dreq_valid, v.exp_req);
    chk({v.name, " stallM"}, stallM, v.exp_req);
    if (!v.exp_req) begin
      chk({v.name, " result"}, dataM.result, v.exp_result);
      chk({v.name, " valid"}, dataM.valid, v.exp_valid);
      chk({v.name, " misalign"}, dataM.misalign, v.exp_mis);
      chk({v.name, " regwrite"}, dataM.ctl.regwrite, v.exp_rw);
      chk({v.name, " memwrite"}, dataM.ctl.memwrite, v.exp_mw);
      chk({v.name, " pc"}, dataM.pc, ~v.addr);
    end else begin
      chk({v.name, " strobe"}, dreq_strobe, v.exp_strobe);
      chk({v.name, " data"}, dreq_data, v.exp_data);
      chk({v.name, " addr"}, dreq_addr, v.addr);
      chk({v.name, " size"}, dreq_size, {1'b0, v.sz});
      stalls = 1;
      for (int k = 1; k <= v.lat; k++) begin
        @(posedge clk); #1;
        if (k == v.lat) begin
          dresp_data_ok = 1'b1;
          dresp_data    = v.rdata;
        end
        @(negedge clk);
        if (stallM) stalls++;
        chk({v.name, " wait dreq_valid"}, dreq_valid, 1'b1);
        chk({v.name, " wait strobe"}, dreq_strobe, v.exp_strobe);
        chk({v.name, " wait data"}, dreq_data, v.exp_data);
        chk({v.name, " wait addr"}, dreq_addr, v.addr);
      end
      @(posedge clk); #1;
      dresp_data_ok = 1'b0;
      dresp_data    = 64'h5A5A_5A5A_5A5A_5A5A;
      @(negedge clk);
      chk({v.name, " done stallM"}, stallM, 1'b0);
      chk({v.name, " done dreq_valid"}, dreq_valid, 1'b0);
      chk({v.name, " done valid"}, dataM.valid, 1'b1);
      chk({v.name, " done result"}, dataM.result, v.exp_result);
      chk({v.name, " done pc"}, dataM.pc, ~v.addr);
      chk({v.name, " stall cycles"}, 64'(stalls), 64'(v.lat + 1));
    end
    @(posedge clk); #1;
    set_bubble();
  endtask

  initial begin
    //              name       addr          wd                     rd wr sz uns nop rw lat rdata                   req strobe data                   result                 mis val rw mw
    vecs[0]  = mk("alu_pass", 64'h1234,     64'h0,                 0, 0, 3, 0, 0, 1, 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h1234,              0, 1, 1, 0);
    vecs[1]  = mk("nop_load", 64'h40,       64'h0,                 1, 0, 0, 0, 1, 1, 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h40,                0, 0, 1, 0);
    vecs[2]  = mk("mis_lw",   64'h8002,     64'h0,                 1, 0, 2, 0, 0, 1, 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h8002,              1, 1, 0, 0);
    vecs[3]  = mk("mis_sh",   64'h8001,     64'h1,                 0, 1, 1, 0, 0, 1, 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h8001,              1, 1, 0, 0);
    vecs[4]  = mk("mis_ld",   64'h8004,     64'h0,                 1, 0, 3, 0, 0, 1, 0, 64'h0,                 0, 8'h00, 64'h0,                 64'h8004,              1, 1, 0, 0);
    vecs[5]  = mk("lb",       64'h8003,     64'h0,                 1, 0, 0, 0, 0, 1, 2, 64'h0000_0000_8000_0000, 1, 8'h00, 64'h0,               64'hFFFF_FFFF_FFFF_FF80, 0, 1, 1, 0);
    vecs[6]  = mk("lhu",      64'h8006,     64'h0,                 1, 0, 1, 1, 0, 1, 1, 64'hBEEF_0000_0000_0000, 1, 8'h00, 64'h0,               64'h0000_0000_0000_BEEF, 0, 1, 1, 0);
    vecs[7]  = mk("sw",       64'h8004,     64'hDEAD_BEEF,         0, 1, 2, 0, 0, 0, 3, 64'h0,                 1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0,                 0, 1, 0, 1);
    vecs[8]  = mk("ld",       64'h1_0008,   64'h0,                 1, 0, 3, 0, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 1, 8'h00, 64'h0,               64'h0123_4567_89AB_CDEF, 0, 1, 1, 0);
    vecs[9]  = mk("lh",       64'h8002,     64'h0,                 1, 0, 1, 0, 0, 1, 1, 64'h0000_0000_8001_0000, 1, 8'h00, 64'h0,               64'hFFFF_FFFF_FFFF_8001, 0, 1, 1, 0);
    vecs[10] = mk("sb",       64'h8007,     64'h12AB,              0, 1, 0, 0, 0, 0, 1, 64'h0,                 1, 8'h80, 64'hAB00_0000_0000_0000, 64'h0,                 0, 1, 0, 1);
    vecs[11] = mk("lwu",      64'h8000,     64'h0,                 1, 0, 2, 1, 0, 1, 1, 64'h1111_2222_F000_0001, 1, 8'h00, 64'h0,               64'h0000_0000_F000_0001, 0, 1, 1, 0);
    vecs[12] = mk("lw",       64'h8004,     64'h0,                 1, 0, 2, 0, 0, 1, 2, 64'hF000_0001_0000_0000, 1, 8'h00, 64'h0,               64'hFFFF_FFFF_F000_0001, 0, 1, 1, 0);
    vecs[13] = mk("sd",       64'h20,       64'h0102_0304_0506_0708, 0, 1, 3, 0, 0, 0, 1, 64'h0,               1, 8'hFF, 64'h0102_0304_0506_0708, 64'h0,                 0, 1, 0, 1);
    vecs[14] = mk("sh",       64'h8002,     64'hCAFE,              0, 1, 1, 0, 0, 0, 2, 64'h0,                 1, 8'h0C, 64'h0000_0000_CAFE_0000, 64'h0,                 0, 1, 0, 1);

    reset         = 1'b1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    set_bubble();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset dreq_valid", dreq_valid, 1'b0);
    chk("reset stallM", stallM, 1'b0);
    chk("reset valid", dataM.valid, 1'b0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset while a request is outstanding.
    @(posedge clk); #1;
    drive(mk("rst", 64'h8000, 64'h0, 1, 0, 3, 0, 0, 1, 0, 64'h0, 0, 8'h0, 64'h0, 64'h0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst req", dreq_valid, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst wait dreq_valid", dreq_valid, 1'b1);
    chk("rst wait stallM", stallM, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    set_bubble();
    @(negedge clk);
    chk("rst after dreq_valid", dreq_valid, 1'b0);
    chk("rst after stallM", stallM, 1'b0);
    chk("rst after valid", dataM.valid, 1'b0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h7777_7777_7777_7777;
    @(negedge clk);
    chk("late ok valid", dataM.valid, 1'b0);
    chk("late ok stallM", stallM, 1'b0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("late ok no done valid", dataM.valid, 1'b0);
    chk("late ok no done dreq", dreq_valid, 1'b0);

    // data_ok while idle with an ALU op must not disturb the passthrough.
    @(posedge clk); #1;
    drive(mk("idle_ok", 64'h55, 64'h0, 0, 0, 0, 0, 0, 1, 0, 64'h0, 0, 8'h0, 64'h0, 64'h0, 0, 0, 0, 0));
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h99;
    @(negedge clk);
    chk("idle ok result", dataM.result, 64'h55);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("idle ok next result", dataM.result, 64'h55);
    chk("idle ok next stallM", stallM, 1'b0);
    @(posedge clk); #1;
    set_bubble();

    // Transactions still work after a mid-transaction reset.
    run_vec(vecs[5]);
    run_vec(vecs[7]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
